// File: rtl/uart_rx_fifo_if.sv
// Receiver capture and FIFO drain signals of uart_rx_fifo, bundled as one interface.
// The slave modport is the buffer; the master modport is the receiver-plus-consumer side.
interface uart_rx_fifo_if #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 8
);
   logic                  rx_rdy;
   logic [WIDTH-1:0]      rx_data;
   logic                  rx_rdy_clr;
   logic [WIDTH-1:0]      m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DEPTH_LOG2:0]   count;
   logic                  overflow;
   logic                  ovf_clr;

   modport slave (
      input  rx_rdy, rx_data, m_ready, ovf_clr,
      output rx_rdy_clr, m_data, m_valid, count, overflow
   );

   modport master (
      output rx_rdy, rx_data, m_ready, ovf_clr,
      input  rx_rdy_clr, m_data, m_valid, count, overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Captures each UART receiver byte once per rx_rdy assertion, acknowledges it with a
// one-cycle clear pulse, and buffers it in a first-word-fall-through FIFO.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int WIDTH      = 8
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   uart_rx_fifo_if.slave     bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CLR  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t                 state_r;
   state_t                 state_next_s;
   logic                   push_s;
   logic                   clr_next_s;
   logic                   pop_s;
   logic                   full_s;
   logic                   push_ok_s;
   logic                   drop_s;
   logic                   rx_rdy_clr_r;
   logic                   overflow_r;
   logic [DEPTH_LOG2-1:0]  wr_ptr_r;
   logic [DEPTH_LOG2-1:0]  rd_ptr_r;
   logic [DEPTH_LOG2:0]    count_r;
   logic [WIDTH-1:0]       mem_r [DEPTH];

   // Capture FSM state register.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Capture FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_IDLE:  state_next_s = bus.rx_rdy ? S_CLR : S_IDLE;
         S_CLR:   state_next_s = S_WAIT;
         S_WAIT:  state_next_s = bus.rx_rdy ? S_WAIT : S_IDLE;
         default: state_next_s = S_IDLE;
      endcase
   end

   // Capture FSM outputs: one push attempt on entry and the registered clear request.
   always_comb begin
      push_s     = 1'b0;
      clr_next_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            push_s     = bus.rx_rdy;
            clr_next_s = bus.rx_rdy;
         end
         S_CLR:   clr_next_s = 1'b0;
         S_WAIT:  clr_next_s = 1'b0;
         default: clr_next_s = 1'b0;
      endcase
   end

   // A full FIFO still accepts a push when the head leaves on the same edge.
   always_comb begin
      full_s    = (count_r == FULL_COUNT);
      pop_s     = (count_r != {(DEPTH_LOG2+1){1'b0}}) && bus.m_ready;
      push_ok_s = push_s && (!full_s || pop_s);
      drop_s    = push_s && full_s && !pop_s;
   end

   // Registered clear pulse back to the receiver.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         rx_rdy_clr_r <= 1'b0;
      end else begin
         rx_rdy_clr_r <= clr_next_s;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r <= {DEPTH_LOG2{1'b0}};
         count_r  <= {(DEPTH_LOG2+1){1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         if (push_ok_s && !pop_s) begin
            count_r <= count_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
         end else if (pop_s && !push_ok_s) begin
            count_r <= count_r - {{DEPTH_LOG2{1'b0}}, 1'b1};
         end else begin
            count_r <= count_r;
         end
      end
   end

   // Storage array; contents are never observed while ungated, so no reset.
   always_ff @(posedge clk_50m) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= bus.rx_data;
      end
   end

   // Sticky overflow; a drop on the same edge as a clear keeps the flag set.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         overflow_r <= 1'b0;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
      end else if (bus.ovf_clr) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   assign bus.rx_rdy_clr = rx_rdy_clr_r;
   assign bus.count      = count_r;
   assign bus.overflow   = overflow_r;
   assign bus.m_valid    = (count_r != {(DEPTH_LOG2+1){1'b0}});
   assign bus.m_data     = bus.m_valid ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: capture handshake, ordering across wraps, full-FIFO
// drop and replace, overflow priority, stuck rx_rdy and reset during the clear pulse.
module tb_uart_rx_fifo;
   logic clk_50m;
   logic rst_n;
   int   tests;
   int   fails;
   int   clr_cnt;
   int   clr_base;

   uart_rx_fifo_if #(.DEPTH_LOG2(4), .WIDTH(8)) bus ();

   uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .bus     (bus.slave)
   );

   initial clk_50m = 1'b0;
   always #10 clk_50m = ~clk_50m;

   always @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) clr_cnt <= 0;
      else if (bus.rx_rdy_clr) clr_cnt <= clr_cnt + 1;
   end

   task automatic cyc();
      @(posedge clk_50m);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      bus.rx_data = b;
      bus.rx_rdy  = 1'b1;
      n = 0;
      cyc();
      while (!bus.rx_rdy_clr && n < 5) begin
         cyc();
         n++;
      end
      check("clr_seen", 32'(bus.rx_rdy_clr), 32'd1);
      bus.rx_rdy = 1'b0;
      cyc();
      cyc();
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      check(tag, 32'(bus.m_data), 32'(exp));
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.rx_rdy  = 1'b0;
      bus.rx_data = 8'h00;
      bus.m_ready = 1'b0;
      bus.ovf_clr = 1'b0;
      repeat (3) @(posedge clk_50m);
      #1;
      check("rst_valid", 32'(bus.m_valid), 32'd0);
      check("rst_data", 32'(bus.m_data), 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_ovf", 32'(bus.overflow), 32'd0);
      check("rst_clr", 32'(bus.rx_rdy_clr), 32'd0);
      rst_n = 1'b1;
      cyc();

      // Single byte capture latency and pop.
      bus.rx_data = 8'hA5;
      bus.rx_rdy  = 1'b1;
      cyc();
      check("a5_clr", 32'(bus.rx_rdy_clr), 32'd1);
      check("a5_valid", 32'(bus.m_valid), 32'd1);
      check("a5_data", 32'(bus.m_data), 32'hA5);
      check("a5_count", 32'(bus.count), 32'd1);
      bus.rx_rdy = 1'b0;
      cyc();
      check("a5_clr_low", 32'(bus.rx_rdy_clr), 32'd0);
      cyc();
      check("a5_pulses", 32'(clr_cnt), 32'd1);
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0;
      check("a5_pop_valid", 32'(bus.m_valid), 32'd0);
      check("a5_pop_data", 32'(bus.m_data), 32'd0);
      check("a5_pop_count", 32'(bus.count), 32'd0);

      // Fill and drain three times so both pointers wrap.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 16; i++) send_byte(8'(i));
         check("fill_count", 32'(bus.count), 32'd16);
         check("fill_ovf", 32'(bus.overflow), 32'd0);
         for (int i = 0; i < 16; i++) pop_check("drain_order", 8'(i));
         check("drain_count", 32'(bus.count), 32'd0);
      end

      // Full FIFO drops a push.
      for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i));
      clr_base = clr_cnt;
      send_byte(8'h55);
      check("drop_ovf", 32'(bus.overflow), 32'd1);
      check("drop_count", 32'(bus.count), 32'd16);
      check("drop_head", 32'(bus.m_data), 32'h10);
      check("drop_pulses", 32'(clr_cnt - clr_base), 32'd1);

      bus.ovf_clr = 1'b1;
      cyc();
      bus.ovf_clr = 1'b0;
      check("ovf_clear", 32'(bus.overflow), 32'd0);

      // Full FIFO with push and pop on the same edge.
      bus.rx_data = 8'h77;
      bus.rx_rdy  = 1'b1;
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0;
      check("swap_count", 32'(bus.count), 32'd16);
      check("swap_ovf", 32'(bus.overflow), 32'd0);
      check("swap_head", 32'(bus.m_data), 32'h11);
      bus.rx_rdy = 1'b0;
      cyc();
      cyc();
      for (int i = 1; i < 16; i++) pop_check("swap_order", 8'h10 + 8'(i));
      pop_check("swap_last", 8'h77);
      check("swap_empty", 32'(bus.m_valid), 32'd0);

      // Drop and clear on the same edge: set wins.
      for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
      bus.rx_data = 8'h99;
      bus.rx_rdy  = 1'b1;
      bus.ovf_clr = 1'b1;
      cyc();
      bus.ovf_clr = 1'b0;
      check("ovf_set_wins", 32'(bus.overflow), 32'd1);
      bus.rx_rdy = 1'b0;
      cyc();
      cyc();
      bus.ovf_clr = 1'b1;
      cyc();
      bus.ovf_clr = 1'b0;
      check("ovf_clr_alone", 32'(bus.overflow), 32'd0);
      for (int i = 0; i < 16; i++) pop_check("ovf_drain", 8'h20 + 8'(i));
      check("ovf_drain_count", 32'(bus.count), 32'd0);

      // Receiver ignores the clear and holds rx_rdy for 10 cycles.
      clr_base = clr_cnt;
      bus.rx_data = 8'h3C;
      bus.rx_rdy  = 1'b1;
      repeat (10) cyc();
      check("stuck_count", 32'(bus.count), 32'd1);
      check("stuck_pulses", 32'(clr_cnt - clr_base), 32'd1);
      check("stuck_clr_low", 32'(bus.rx_rdy_clr), 32'd0);
      bus.rx_rdy = 1'b0;
      cyc();
      bus.rx_data = 8'hC3;
      bus.rx_rdy  = 1'b1;
      cyc();
      check("rearm_count", 32'(bus.count), 32'd2);
      check("rearm_clr", 32'(bus.rx_rdy_clr), 32'd1);

      // Reset while the clear pulse is high.
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_clr", 32'(bus.rx_rdy_clr), 32'd0);
      check("midrst_count", 32'(bus.count), 32'd0);
      check("midrst_valid", 32'(bus.m_valid), 32'd0);
      check("midrst_data", 32'(bus.m_data), 32'd0);
      check("midrst_ovf", 32'(bus.overflow), 32'd0);
      #2;
      rst_n = 1'b1;
      cyc();
      check("recapture_count", 32'(bus.count), 32'd1);
      check("recapture_data", 32'(bus.m_data), 32'hC3);
      check("recapture_clr", 32'(bus.rx_rdy_clr), 32'd1);
      bus.rx_rdy = 1'b0;
      cyc();
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. Runs in the `clk_50m` domain. Each time the receiver raises its ready flag, this block captures the byte, pulses the receiver's ready-clear input, and stores the byte in a first-word-fall-through FIFO. The core logic drains the FIFO through a valid/ready interface, so no byte is lost while the consumer is busy, up to the FIFO depth.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2**DEPTH_LOG2 entries (16).
- `WIDTH`, default 8: byte width.
- `clk_50m`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  reset, asynchronous assert, active low.
- `rx_rdy`  in  1  receiver byte-ready flag; level, held until cleared.
- `rx_data`  in  WIDTH  receiver byte; stable while `rx_rdy`=1.
- `rx_rdy_clr`  out  1  registered clear pulse to the receiver.
- `m_data`  out  WIDTH  head-of-FIFO byte; forced to 0 when `m_valid`=0.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  consumer accepts `m_data` on an edge where `m_valid`=1.
- `count`  out  DEPTH_LOG2+1  number of stored bytes, 0..2**DEPTH_LOG2.
- `overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `ovf_clr`  in  1  synchronous clear of `overflow`.

## Operation
- **Capture FSM states:** IDLE, CLR, WAIT.
  - IDLE: when `rx_rdy`=1, push `rx_data` on the same edge, set `rx_rdy_clr`<=1, and go to CLR.
  - CLR: `rx_rdy_clr` is 1 for exactly this one cycle. On the next edge, set `rx_rdy_clr`<=0 and go to WAIT.
  - WAIT: return to IDLE on the first edge that samples `rx_rdy`=0. If `rx_rdy` stays high, remain in WAIT with no further push and no further clear.
  - Each assertion of `rx_rdy` produces exactly one push attempt.
- **Push outcome:**
  - The push is accepted when `count` < 2**DEPTH_LOG2.
  - The push is also accepted when the FIFO is full and a pop occurs on the same edge.
  - Otherwise the byte is dropped and `overflow`<=1.
- **Pop:** occurs when `m_valid`=1 and `m_ready`=1. The read pointer advances by one.
- **Pointers:** DEPTH_LOG2-bit write and read pointers that wrap modulo the depth. `count` is tracked separately.
- **`count` update:**
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop happen together or when neither happens.
- **First-word fall-through:** `m_data` = mem[rd_ptr] gated by `m_valid`. `m_valid` = (`count` != 0).
- **`overflow` flag:**
  - Set by a dropped push.
  - Cleared by `ovf_clr`.
  - If a drop and `ovf_clr` occur on the same edge, set wins.
- **Memory contents:** not reset. Data is observable only through `m_data`, which is gated.

## Timing
- **Reset values** (asynchronous on `rst_n`=0):
  - FSM = IDLE.
  - `rx_rdy_clr`=0, `count`=0, `m_valid`=0, `m_data`=0, `overflow`=0.
  - Pointers = 0.
- **Capture latency:** if `rx_rdy` is first sampled high at edge E0 and the FIFO is empty:
  - `m_valid`=1 and `m_data`=byte after E0.
  - `rx_rdy_clr` is high from E0 to E1.
  - The receiver drops `rx_rdy` at E1.
  - FSM reaches WAIT at E1 and IDLE at E2.
  - Minimum spacing between captures is 3 cycles, far shorter than one UART frame.
- **Reset mid-operation:**
  - `rst_n` low during CLR drops `rx_rdy_clr` immediately.
  - If `rx_rdy` is still high after reset release, the byte is captured again as a new push.
- **Pop timing:** combinational from `m_ready` only through the pop enable. `m_data` and `m_valid` change only on clock edges.
- **Full FIFO with simultaneous pop and push:** `count` stays at 2**DEPTH_LOG2, the head advances, and the new byte is stored at the tail.
- **Empty FIFO:** `m_ready`=1 has no effect.

## Test plan
- Reset, then `rx_rdy`=1 with `rx_data`=0xA5 held until `rx_rdy_clr` is seen:
  - One `rx_rdy_clr` pulse of 1 cycle.
  - `m_valid`=1, `m_data`=0xA5, `count`=1 one edge after first sample.
  - Pop with `m_ready`=1 -> `m_valid`=0, `m_data`=0, `count`=0.
- Push 0x00..0x0F with `m_ready`=0:
  - `count`=16, `overflow`=0.
  - Drain -> bytes return in order 0x00..0x0F.
  - Repeat twice more to cover pointer wrap.
- With the FIFO full, push 0x55 with `m_ready`=0:
  - Byte dropped, `overflow`=1, `count`=16, head unchanged.
  - `rx_rdy_clr` still pulses once.
- With the FIFO full, push 0x77 on the same edge as a pop:
  - `count`=16, `overflow`=0.
  - 0x77 emerges last after draining.
- `ovf_clr`=1 on the same edge as a dropped push -> `overflow`=1. `ovf_clr` alone -> `overflow`=0.
- Hold `rx_rdy`=1 for 10 cycles (receiver ignoring the clear):
  - Exactly one push and one `rx_rdy_clr` pulse.
  - FSM stays in WAIT until `rx_rdy`=0.
  - Assert `rst_n`=0 during CLR -> all outputs at reset values immediately.
